// File: rtl/bus_pkg.sv
// Shared definitions for the bus decoder: FSM state encoding and the default
// two-slave address map.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int DEFAULT_N_SLAVES = 2;
    localparam int DEFAULT_TIMEOUT  = 15;

    // Packed maps: element [k] describes slave k.
    localparam logic [1:0][31:0] DEFAULT_BASE_ADDR   = {32'h0001_0000, 32'h0000_0000};
    localparam logic [1:0][31:0] DEFAULT_REGION_SIZE = {32'd4096, 32'd4096};

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational check of whether an address falls inside one slave region,
// i.e. BASE <= addr < BASE + SIZE, evaluated in 33 bits so the end may reach 2^32.
module addr_region_match #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] SIZE = 32'd4096
) (
    input  logic [31:0] addr,
    output logic        hit
);

    localparam logic [32:0] LIMIT = {1'b0, BASE} + {1'b0, SIZE};

    assign hit = (addr >= BASE) && ({1'b0, addr} < LIMIT);

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-slave address decoder with per-access response timeout
// and error reporting for unmapped or unresponsive accesses.
module bus_decoder
    import bus_pkg::*;
#(
    parameter int                         N_SLAVES    = DEFAULT_N_SLAVES,
    parameter logic [N_SLAVES-1:0][31:0]  BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter logic [N_SLAVES-1:0][31:0]  REGION_SIZE = DEFAULT_REGION_SIZE,
    parameter int                         TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  m_add_i,
    input  logic [31:0]                  m_wdata_i,
    input  logic [3:0]                   m_ble_i,
    input  logic                         m_re_i,
    input  logic                         m_we_i,
    output logic [31:0]                  m_rdata_o,
    output logic                         m_valid_o,
    output logic                         m_err_o,
    output logic [31:0]                  s_add_o,
    output logic [31:0]                  s_wdata_o,
    output logic [3:0]                   s_ble_o,
    output logic [N_SLAVES-1:0]          s_re_o,
    output logic [N_SLAVES-1:0]          s_we_o,
    input  logic [N_SLAVES-1:0][31:0]    s_rdata_i,
    input  logic [N_SLAVES-1:0]          s_valid_i,
    output logic [31:0]                  err_addr_o
);

    localparam int SEL_W = sel_width(N_SLAVES);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [31:0]        err_addr_reg, err_addr_next;

    logic [N_SLAVES-1:0] hit;
    logic                any_hit;
    logic [SEL_W-1:0]    hit_idx;
    logic                request;

    assign request    = m_re_i | m_we_i;
    assign s_add_o    = m_add_i;
    assign s_wdata_o  = m_wdata_i;
    assign s_ble_o    = m_ble_i;
    assign err_addr_o = err_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_match
            addr_region_match #(
                .BASE (BASE_ADDR[gi]),
                .SIZE (REGION_SIZE[gi])
            ) u_match (
                .addr (m_add_i),
                .hit  (hit[gi])
            );
        end
    endgenerate

    // Scan from the top down so the lowest-numbered overlapping slave wins.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        timer_next    = timer_reg;
        err_addr_next = err_addr_reg;
        s_re_o        = '0;
        s_we_o        = '0;
        m_valid_o     = 1'b0;
        m_err_o       = 1'b0;
        m_rdata_o     = '0;

        // Outputs are held quiet while reset is asserted, even if a request is present.
        if (!rst_i) begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        if (any_hit) begin
                            s_re_o[hit_idx] = m_re_i;
                            s_we_o[hit_idx] = m_we_i;
                            sel_next        = hit_idx;
                            if (s_valid_i[hit_idx]) begin
                                m_valid_o = 1'b1;
                                m_rdata_o = s_rdata_i[hit_idx];
                            end else begin
                                state_next = ACCESS;
                                timer_next = '0;
                            end
                        end else begin
                            err_addr_next = m_add_i;
                            state_next    = ERROR;
                        end
                    end
                end

                ACCESS: begin
                    if (!request) begin
                        state_next = IDLE;
                    end else begin
                        s_re_o[sel_reg] = m_re_i;
                        s_we_o[sel_reg] = m_we_i;
                        if (s_valid_i[sel_reg]) begin
                            m_valid_o  = 1'b1;
                            m_rdata_o  = s_rdata_i[sel_reg];
                            state_next = IDLE;
                        end else if (timer_reg == TMR_W'(TIMEOUT)) begin
                            m_valid_o     = 1'b1;
                            m_err_o       = 1'b1;
                            err_addr_next = m_add_i;
                            state_next    = IDLE;
                        end else begin
                            timer_next = timer_reg + TMR_W'(1);
                        end
                    end
                end

                ERROR: begin
                    m_valid_o  = 1'b1;
                    m_err_o    = 1'b1;
                    state_next = IDLE;
                end

                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            timer_reg    <= '0;
            err_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            timer_reg    <= timer_next;
            err_addr_reg <= err_addr_next;
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed-vector bench for bus_decoder: default map instance plus a second
// instance with fully overlapping regions.
module tb_bus_decoder;

    logic              clk;
    logic              rst;
    logic [31:0]       m_add;
    logic [31:0]       m_wdata;
    logic [3:0]        m_ble;
    logic              m_re;
    logic              m_we;
    logic [31:0]       m_rdata;
    logic              m_valid;
    logic              m_err;
    logic [31:0]       s_add;
    logic [31:0]       s_wdata;
    logic [3:0]        s_ble;
    logic [1:0]        s_re;
    logic [1:0]        s_we;
    logic [1:0][31:0]  s_rdata;
    logic [1:0]        s_valid;
    logic [31:0]       err_addr;

    logic [31:0]       ov_rdata;
    logic              ov_valid;
    logic              ov_err;
    logic [31:0]       ov_s_add;
    logic [31:0]       ov_s_wdata;
    logic [3:0]        ov_s_ble;
    logic [1:0]        ov_s_re;
    logic [1:0]        ov_s_we;
    logic [31:0]       ov_err_addr;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam logic [1:0][31:0] OV_BASE = '0;
    localparam logic [1:0][31:0] OV_SIZE = {32'd4096, 32'd4096};

    bus_decoder u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_add_i    (m_add),
        .m_wdata_i  (m_wdata),
        .m_ble_i    (m_ble),
        .m_re_i     (m_re),
        .m_we_i     (m_we),
        .m_rdata_o  (m_rdata),
        .m_valid_o  (m_valid),
        .m_err_o    (m_err),
        .s_add_o    (s_add),
        .s_wdata_o  (s_wdata),
        .s_ble_o    (s_ble),
        .s_re_o     (s_re),
        .s_we_o     (s_we),
        .s_rdata_i  (s_rdata),
        .s_valid_i  (s_valid),
        .err_addr_o (err_addr)
    );

    bus_decoder #(
        .N_SLAVES    (2),
        .BASE_ADDR   (OV_BASE),
        .REGION_SIZE (OV_SIZE),
        .TIMEOUT     (15)
    ) u_dut_ov (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_add_i    (m_add),
        .m_wdata_i  (m_wdata),
        .m_ble_i    (m_ble),
        .m_re_i     (m_re),
        .m_we_i     (m_we),
        .m_rdata_o  (ov_rdata),
        .m_valid_o  (ov_valid),
        .m_err_o    (ov_err),
        .s_add_o    (ov_s_add),
        .s_wdata_o  (ov_s_wdata),
        .s_ble_o    (ov_s_ble),
        .s_re_o     (ov_s_re),
        .s_we_o     (ov_s_we),
        .s_rdata_i  (s_rdata),
        .s_valid_i  (s_valid),
        .err_addr_o (ov_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  exp_re;
    } bnd_vec_t;

    bnd_vec_t bnd_tbl [3];

    initial begin
        bnd_tbl[0] = '{32'h0000_0FFF, 2'b01};
        bnd_tbl[1] = '{32'h0001_0000, 2'b10};
        bnd_tbl[2] = '{32'h0001_0FFF, 2'b10};

        rst     = 1'b1;
        m_add   = '0;
        m_wdata = '0;
        m_ble   = '0;
        m_re    = 1'b0;
        m_we    = 1'b0;
        s_rdata = '0;
        s_valid = '0;

        // Reset state, with a request present to show outputs stay quiet.
        step();
        m_re  = 1'b1;
        m_add = 32'h0000_0010;
        settle();
        check("rst_s_re", 32'(s_re), 32'h0);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_err", 32'(m_err), 32'h0);
        check("rst_rdata", m_rdata, 32'h0);
        step();
        check("rst_err_addr", err_addr, 32'h0);
        rst  = 1'b0;
        m_re = 1'b0;
        settle();
        check("post_rst_valid", 32'(m_valid), 32'h0);
        $display("txn reset done");

        // Write to slave 0, completing in the same cycle.
        step();
        m_add      = 32'h0000_0010;
        m_wdata    = 32'h1234_5678;
        m_ble      = 4'b0011;
        m_we       = 1'b1;
        s_valid    = 2'b01;
        s_rdata[0] = 32'hA5A5_0000;
        settle();
        check("wr_s_we", 32'(s_we), 32'h1);
        check("wr_s_re", 32'(s_re), 32'h0);
        check("wr_valid", 32'(m_valid), 32'h1);
        check("wr_err", 32'(m_err), 32'h0);
        check("wr_rdata", m_rdata, 32'hA5A5_0000);
        check("wr_s_add", s_add, 32'h0000_0010);
        check("wr_s_wdata", s_wdata, 32'h1234_5678);
        check("wr_s_ble", 32'(s_ble), 32'h3);
        $display("txn write addr=0x00000010 ble=0011");

        // Back-to-back read to slave 1; valid arrives two cycles later.
        step();
        m_we       = 1'b0;
        m_re       = 1'b1;
        m_add      = 32'h0001_0004;
        s_valid    = 2'b00;
        settle();
        check("rd_c0_s_re", 32'(s_re), 32'h2);
        check("rd_c0_valid", 32'(m_valid), 32'h0);
        step();
        s_valid    = 2'b01;
        s_rdata[0] = 32'h1111_1111;
        settle();
        check("rd_c1_s_re", 32'(s_re), 32'h2);
        check("rd_c1_unsel_valid", 32'(m_valid), 32'h0);
        check("rd_c1_rdata", m_rdata, 32'h0);
        step();
        s_valid    = 2'b11;
        s_rdata[1] = 32'hDEAD_BEEF;
        settle();
        check("rd_c2_valid", 32'(m_valid), 32'h1);
        check("rd_c2_rdata", m_rdata, 32'hDEAD_BEEF);
        check("rd_c2_err", 32'(m_err), 32'h0);
        step();
        m_re    = 1'b0;
        s_valid = 2'b00;
        settle();
        check("rd_c3_valid", 32'(m_valid), 32'h0);
        check("rd_c3_rdata", m_rdata, 32'h0);
        $display("txn read addr=0x00010004 data=0xdeadbeef");

        // Master abandons an access while waiting.
        step();
        m_re  = 1'b1;
        m_add = 32'h0001_0008;
        settle();
        step();
        m_re = 1'b0;
        settle();
        check("abort_valid", 32'(m_valid), 32'h0);
        check("abort_err", 32'(m_err), 32'h0);
        step();
        m_we    = 1'b1;
        m_add   = 32'h0000_0020;
        s_valid = 2'b01;
        settle();
        check("abort_next_valid", 32'(m_valid), 32'h1);
        check("abort_next_s_we", 32'(s_we), 32'h1);
        step();
        m_we    = 1'b0;
        s_valid = 2'b00;
        settle();
        $display("txn abort addr=0x00010008");

        // Unmapped address.
        step();
        m_re    = 1'b1;
        m_add   = 32'h0002_0000;
        s_rdata = {32'h7777_7777, 32'h6666_6666};
        settle();
        check("miss_c0_s_re", 32'(s_re), 32'h0);
        check("miss_c0_valid", 32'(m_valid), 32'h0);
        step();
        check("miss_c1_valid", 32'(m_valid), 32'h1);
        check("miss_c1_err", 32'(m_err), 32'h1);
        check("miss_c1_rdata", m_rdata, 32'h0);
        check("miss_c1_s_re", 32'(s_re), 32'h0);
        check("miss_err_addr", err_addr, 32'h0002_0000);
        step();
        m_re = 1'b0;
        settle();
        check("miss_c2_valid", 32'(m_valid), 32'h0);
        $display("txn miss addr=0x00020000");

        // Reset two cycles into an ACCESS.
        step();
        m_re    = 1'b1;
        m_add   = 32'h0000_0100;
        s_valid = 2'b00;
        step();
        step();
        rst = 1'b1;
        settle();
        check("midrst_s_re", 32'(s_re), 32'h0);
        check("midrst_valid", 32'(m_valid), 32'h0);
        step();
        rst  = 1'b0;
        m_re = 1'b0;
        settle();
        check("midrst_after_valid", 32'(m_valid), 32'h0);
        check("midrst_after_err", 32'(m_err), 32'h0);
        check("midrst_after_rdata", m_rdata, 32'h0);
        check("midrst_after_s_re", 32'(s_re), 32'h0);
        check("midrst_err_addr", err_addr, 32'h0);
        step();
        m_re       = 1'b1;
        m_add      = 32'h0001_0004;
        s_valid    = 2'b10;
        s_rdata[1] = 32'hCAFE_F00D;
        settle();
        check("midrst_next_s_re", 32'(s_re), 32'h2);
        check("midrst_next_valid", 32'(m_valid), 32'h1);
        check("midrst_next_rdata", m_rdata, 32'hCAFE_F00D);
        step();
        m_re    = 1'b0;
        s_valid = 2'b00;
        settle();
        $display("txn reset-in-access");

        // Give err_addr a nonzero value before the timeout overwrites it.
        step();
        m_re  = 1'b1;
        m_add = 32'h0003_0000;
        step();
        step();
        m_re = 1'b0;
        settle();
        check("pre_to_err_addr", err_addr, 32'h0003_0000);

        // Slave 0 never answers: error pulse 16 cycles after the request.
        step();
        m_re  = 1'b1;
        m_add = 32'h0000_0000;
        settle();
        check("to_c0_s_re", 32'(s_re), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("to_c%0d_valid", i), 32'(m_valid), 32'h0);
        end
        step();
        check("to_c16_valid", 32'(m_valid), 32'h1);
        check("to_c16_err", 32'(m_err), 32'h1);
        check("to_c16_rdata", m_rdata, 32'h0);
        step();
        m_re = 1'b0;
        settle();
        check("to_err_addr", err_addr, 32'h0000_0000);
        check("to_c17_valid", 32'(m_valid), 32'h0);
        $display("txn timeout addr=0x00000000");

        // Region boundaries, each completing in its request cycle.
        foreach (bnd_tbl[i]) begin
            step();
            m_re    = 1'b1;
            m_add   = bnd_tbl[i].addr;
            s_valid = 2'b11;
            settle();
            check($sformatf("bnd%0d_s_re", i), 32'(s_re), 32'(bnd_tbl[i].exp_re));
            check($sformatf("bnd%0d_valid", i), 32'(m_valid), 32'h1);
            $display("txn boundary addr=0x%08h", bnd_tbl[i].addr);
        end
        step();
        m_add   = 32'h0000_1000;
        s_valid = 2'b00;
        settle();
        check("bnd_miss_s_re", 32'(s_re), 32'h0);
        step();
        check("bnd_miss_err", 32'(m_err), 32'h1);
        step();
        m_re = 1'b0;
        settle();
        $display("txn boundary miss addr=0x00001000");

        // Overlapping regions: lowest slave wins.
        step();
        m_re    = 1'b1;
        m_add   = 32'h0000_0080;
        s_valid = 2'b11;
        s_rdata = {32'h2222_2222, 32'h3333_3333};
        settle();
        check("ov_s_re", 32'(ov_s_re), 32'h1);
        check("ov_valid", 32'(ov_valid), 32'h1);
        check("ov_rdata", ov_rdata, 32'h3333_3333);
        step();
        m_re    = 1'b0;
        s_valid = 2'b00;
        settle();
        check("ov_after_valid", 32'(ov_valid), 32'h0);
        $display("txn overlap addr=0x00000080");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
